load_store_unit: RTL

- Data-memory side counterpart of the instruction decoder's memory controls.
- Consumes `mem_d_we`, `mem_d_wdsrc` (store width) and the load `dataout_src` codes (RDS8/RDS16/RD32/RDZ8/RDZ16) from the execute stage.
- Performs one aligned data-bus transaction per request over a valid/ready request channel and a valid response channel.
- Returns load data with the correct sign or zero extension; checks alignment; bounds bus response time with a timeout.

---
 rtl/load_store_unit_pkg.sv | 22 ++
 rtl/load_store_unit_if.sv | 38 +++
 rtl/load_store_unit_align.sv | 73 +++++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the data-memory path and the load/store unit state type.
package load_store_unit_pkg;

    localparam logic [1:0] EXE_MEMWDSRC_B = 2'd0;
    localparam logic [1:0] EXE_MEMWDSRC_H = 2'd1;
    localparam logic [1:0] EXE_MEMWDSRC_W = 2'd2;

    localparam logic [2:0] EXE_DATAOUTSRC_RD32  = 3'd0;
    localparam logic [2:0] EXE_DATAOUTSRC_RDS8  = 3'd1;
    localparam logic [2:0] EXE_DATAOUTSRC_RDS16 = 3'd2;
    localparam logic [2:0] EXE_DATAOUTSRC_RDZ8  = 3'd3;
    localparam logic [2:0] EXE_DATAOUTSRC_RDZ16 = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT_RSP = 3'd2,
        RSP      = 3'd3,
        ERR      = 3'd4
    } lsu_state_t;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response channel plus data-bus channel of the load/store unit.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_wdsrc;
    logic [2:0]  req_ldsrc;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_rsp_valid;
    logic        bus_rsp_err;
    logic [31:0] bus_rdata;

    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    modport master (
        input  req_valid, req_we, req_wdsrc, req_ldsrc, req_addr, req_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
        output req_ready, bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        output rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        output req_valid, req_we, req_wdsrc, req_ldsrc, req_addr, req_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_err, bus_rdata,
        input  req_ready, bus_req_valid, bus_addr, bus_we, bus_be, bus_wdata,
        input  rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for stores, lane select plus extension for loads, alignment check.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  wdsrc,
    input  logic [2:0]  ldsrc,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);
    logic [31:0] shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign shifted = rdata_word >> {addr_lo, 3'b000};
    assign rd_byte = shifted[7:0];
    assign rd_half = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

    always_comb begin
        be         = 4'hF;
        wdata_lane = wdata;
        if (we) begin
            case (wdsrc)
                EXE_MEMWDSRC_B: begin
                    be         = 4'b0001 << addr_lo;
                    wdata_lane = {4{wdata[7:0]}};
                end
                EXE_MEMWDSRC_H: begin
                    be         = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_lane = {2{wdata[15:0]}};
                end
                default: begin
                    be         = 4'hF;
                    wdata_lane = wdata;
                end
            endcase
        end
    end

    always_comb begin
        case (ldsrc)
            EXE_DATAOUTSRC_RDS8:  rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            EXE_DATAOUTSRC_RDZ8:  rdata_ext = {24'd0, rd_byte};
            EXE_DATAOUTSRC_RDS16: rdata_ext = {{16{rd_half[15]}}, rd_half};
            EXE_DATAOUTSRC_RDZ16: rdata_ext = {16'd0, rd_half};
            default:              rdata_ext = rdata_word;
        endcase
    end

    // Undefined width codes fall back to the word rules, so they need full alignment.
    always_comb begin
        if (we) begin
            case (wdsrc)
                EXE_MEMWDSRC_B: misaligned = 1'b0;
                EXE_MEMWDSRC_H: misaligned = addr_lo[0];
                default:        misaligned = |addr_lo;
            endcase
        end else begin
            case (ldsrc)
                EXE_DATAOUTSRC_RDS8,
                EXE_DATAOUTSRC_RDZ8:  misaligned = 1'b0;
                EXE_DATAOUTSRC_RDS16,
                EXE_DATAOUTSRC_RDZ16: misaligned = addr_lo[0];
                default:              misaligned = |addr_lo;
            endcase
        end
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one aligned data-bus access per request, bounded by a response timeout.
//   state    | meaning
//   IDLE     | ready for a request
//   REQ      | bus request presented, waiting for bus_req_ready
//   WAIT_RSP | request accepted, waiting for bus response
//   RSP      | one-cycle completion pulse
//   ERR      | one-cycle error pulse (misaligned / timeout)
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.master lsu
);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state, state_nxt;
    logic        cap_we;
    logic [1:0]  cap_wdsrc;
    logic [2:0]  cap_ldsrc;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [31:0] rsp_word;
    logic        rsp_err_q;
    logic [15:0] tmo_cnt;

    logic        in_idle;
    logic        accept;
    logic        rsp_take;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;
    logic        al_mis;

    assign in_idle  = (state == IDLE);
    assign accept   = in_idle && lsu.req_valid;
    assign rsp_take = lsu.bus_rsp_valid &&
                      ((state == REQ && lsu.bus_req_ready) || state == WAIT_RSP);

    // In IDLE the aligner looks at the incoming request so misalignment is known at accept.
    load_store_unit_align u_align (
        .we         (in_idle ? lsu.req_we    : cap_we),
        .wdsrc      (in_idle ? lsu.req_wdsrc : cap_wdsrc),
        .ldsrc      (in_idle ? lsu.req_ldsrc : cap_ldsrc),
        .addr_lo    (in_idle ? lsu.req_addr[1:0] : cap_addr[1:0]),
        .wdata      (in_idle ? lsu.req_wdata : cap_wdata),
        .rdata_word (rsp_word),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misaligned (al_mis)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = al_mis ? ERR : REQ;
            REQ:      if (lsu.bus_req_ready) state_nxt = lsu.bus_rsp_valid ? RSP : WAIT_RSP;
            WAIT_RSP: begin
                if (lsu.bus_rsp_valid)      state_nxt = RSP;
                else if (tmo_cnt == TMO_LAST) state_nxt = ERR;
            end
            RSP:      state_nxt = IDLE;
            ERR:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_we    <= 1'b0;
            cap_wdsrc <= 2'd0;
            cap_ldsrc <= 3'd0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            rsp_word  <= 32'd0;
            rsp_err_q <= 1'b0;
            tmo_cnt   <= 16'd0;
        end else begin
            if (accept) begin
                cap_we    <= lsu.req_we;
                cap_wdsrc <= lsu.req_wdsrc;
                cap_ldsrc <= lsu.req_ldsrc;
                cap_addr  <= lsu.req_addr;
                cap_wdata <= lsu.req_wdata;
                rsp_err_q <= 1'b0;
            end else if (rsp_take) begin
                rsp_word  <= lsu.bus_rdata;
                rsp_err_q <= lsu.bus_rsp_err;
            end
            tmo_cnt <= (state == WAIT_RSP) ? tmo_cnt + 16'd1 : 16'd0;
        end
    end

    always_comb begin
        lsu.req_ready     = in_idle;
        lsu.bus_req_valid = (state == REQ);
        lsu.bus_addr      = 32'd0;
        lsu.bus_we        = 1'b0;
        lsu.bus_be        = 4'd0;
        lsu.bus_wdata     = 32'd0;
        lsu.rsp_valid     = 1'b0;
        lsu.rsp_err       = 1'b0;
        lsu.rsp_rdata     = 32'd0;
        case (state)
            REQ: begin
                lsu.bus_addr  = {cap_addr[31:2], 2'b00};
                lsu.bus_we    = cap_we;
                lsu.bus_be    = al_be;
                lsu.bus_wdata = cap_we ? al_wdata : 32'd0;
            end
            RSP: begin
                lsu.rsp_valid = 1'b1;
                lsu.rsp_err   = rsp_err_q;
                lsu.rsp_rdata = (cap_we || rsp_err_q) ? 32'd0 : al_rdata;
            end
            ERR: begin
                lsu.rsp_valid = 1'b1;
                lsu.rsp_err   = 1'b1;
            end
            default: ;
        endcase
    end
endmodule
